// File: rtl/multi_db_fsm.sv
// Multi-channel switch/button debouncer with a shared sample-tick prescaler.
// Optional long-press detection is enabled by defining DB_LONG_PRESS_EN.
module multi_db_fsm #(
    parameter int NCH          = 4,
    parameter int TICK_BITS    = 19,
    parameter int STABLE_TICKS = 3,
    parameter int LONG_TICKS   = 100
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] sw,
    output logic [NCH-1:0] db,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic [NCH-1:0] long_press,
    output logic           tick
);

    localparam int CNT_W = $clog2(STABLE_TICKS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    // Encoding puts the debounced level in state[1], so db comes straight off a flop.
    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } state_t;

    logic [TICK_BITS-1:0] q;
    logic [NCH-1:0]       sync1;
    logic [NCH-1:0]       sw_s;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q + TICK_BITS'(1);
        end
    end

    assign tick = (q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sw_s  <= '0;
        end else begin
            sync1 <= sw;
            sw_s  <= sync1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t           state;
        state_t           state_nx;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nx;
        logic             rise_r;
        logic             fall_r;
        logic             high_now;
        logic             high_nx;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state  <= ZERO;
                cnt    <= '0;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
            end else begin
                state  <= state_nx;
                cnt    <= cnt_nx;
                rise_r <= high_nx & ~high_now;
                fall_r <= high_now & ~high_nx;
            end
        end

        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            unique case (state)
                ZERO: begin
                    if (sw_s[i]) begin
                        state_nx = WAIT1;
                        cnt_nx   = '0;
                    end
                end
                WAIT1: begin
                    if (!sw_s[i]) begin
                        state_nx = ZERO;
                    end else if (tick && cnt == CNT_LAST) begin
                        state_nx = ONE;
                    end else if (tick) begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                ONE: begin
                    if (!sw_s[i]) begin
                        state_nx = WAIT0;
                        cnt_nx   = '0;
                    end
                end
                WAIT0: begin
                    if (sw_s[i]) begin
                        state_nx = ONE;
                    end else if (tick && cnt == CNT_LAST) begin
                        state_nx = ZERO;
                    end else if (tick) begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                default: state_nx = ZERO;
            endcase
        end

        assign high_now = state[1];
        assign high_nx  = state_nx[1];
        assign db[i]    = high_now;
        assign rise[i]  = rise_r;
        assign fall[i]  = fall_r;

`ifdef DB_LONG_PRESS_EN
        localparam int LP_W = $clog2(LONG_TICKS + 1);
        localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_TICKS - 1);

        logic [LP_W-1:0] lcnt;
        logic            fired;
        logic            lp_r;

        // The counter stops once fired, so it cannot wrap and fire again within one press.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                lcnt  <= '0;
                fired <= 1'b0;
                lp_r  <= 1'b0;
            end else begin
                lp_r <= 1'b0;
                if (state_nx == ONE && state != ONE) begin
                    lcnt <= '0;
                end else if (tick && high_now && !fired) begin
                    lcnt <= lcnt + LP_W'(1);
                    if (lcnt == LP_LAST) begin
                        lp_r  <= 1'b1;
                        fired <= 1'b1;
                    end
                end
                if (state == ZERO) begin
                    fired <= 1'b0;
                end
            end
        end

        assign long_press[i] = lp_r;
`else
        assign long_press[i] = 1'b0;
`endif
    end

endmodule
